// File: rtl/sort_pkg.sv
// Shared constants and types for the sorter front end and back end.
package sort_pkg;

  localparam int SORT_N   = 8;
  localparam int SORT_W   = 8;
  localparam int LEN_W    = 4;
  localparam int SORT_LAT = 2;

  typedef enum logic {FILL, PEND} state_t;

endpackage

// File: rtl/sort_loader_if.sv
// Byte-stream input, stall and committed-frame bundle between the feeder and the sorter.
interface sort_loader_if
  import sort_pkg::*;
#(
  parameter int W = SORT_W
);
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             hold;
  logic [W-1:0]     frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8;
  logic             sorted_valid;
  logic [LEN_W-1:0] sorted_len;
  logic [15:0]      frame_cnt;

  modport master (
    output in_data, in_valid, in_last, hold,
    input  in_ready, frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8,
    input  sorted_valid, sorted_len, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, hold,
    output in_ready, frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8,
    output sorted_valid, sorted_len, frame_cnt
  );
endinterface

// File: rtl/sort_align_delay.sv
// Fixed-depth shift chain carrying a strobe and its length, used to line up
// side information with the sorter pipeline.
module sort_align_delay
  import sort_pkg::*;
#(
  parameter int DEPTH = SORT_LAT + 1,
  parameter int LW    = LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_pulse,
  input  logic [LW-1:0] in_len,
  output logic          out_pulse,
  output logic [LW-1:0] out_len
);
  logic [DEPTH-1:0] pulse_q, pulse_d;
  logic [LW-1:0]    len_q [DEPTH];
  logic [LW-1:0]    len_d [DEPTH];

  // Length is zeroed when no strobe enters so idle stages read as 0.
  always_comb begin
    pulse_d = {pulse_q[DEPTH-2:0], in_pulse};
    len_d[0] = in_pulse ? in_len : '0;
    for (int i = 1; i < DEPTH; i++) len_d[i] = len_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      for (int i = 0; i < DEPTH; i++) len_q[i] <= '0;
    end else begin
      pulse_q <= pulse_d;
      for (int i = 0; i < DEPTH; i++) len_q[i] <= len_d[i];
    end
  end

  assign out_pulse = pulse_q[DEPTH-1];
  assign out_len   = len_q[DEPTH-1];
endmodule

// File: rtl/sort_loader.sv
// Packs a byte stream into 8-byte frames and commits them atomically to the sorter inputs;
// a delayed strobe/length marks when the sorter outputs hold each committed frame.
module sort_loader
  import sort_pkg::*;
#(
  parameter int           W   = SORT_W,
  parameter logic [W-1:0] PAD = '0
) (
  input logic          clk,
  input logic          rst_n,
  sort_loader_if.slave bus
);
  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [W-1:0]     shadow_q [SORT_N];
  logic [W-1:0]     shadow_d [SORT_N];
  logic [W-1:0]     frm_q [SORT_N];
  logic [W-1:0]     frm_d [SORT_N];
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             up_q, up_d;
  logic             in_ready, accept, complete, commit;
  logic [LEN_W-1:0] commit_len, fill_len;

  // up_q keeps in_ready low until the first edge after reset release.
  assign in_ready = up_q && (state_q == FILL);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && ((fcnt_q == 3'd7) || bus.in_last);
  assign fill_len = LEN_W'(fcnt_q) + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    len_d       = len_q;
    shadow_d    = shadow_q;
    frm_d       = frm_q;
    frame_cnt_d = frame_cnt_q;
    up_d        = 1'b1;
    commit      = 1'b0;
    commit_len  = len_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          shadow_d[fcnt_q] = bus.in_data;
          if (!complete) begin
            fcnt_d = fcnt_q + 3'd1;
          end else if (bus.hold) begin
            state_d = PEND;
            len_d   = fill_len;
          end else begin
            commit     = 1'b1;
            commit_len = fill_len;
          end
        end
      end
      PEND: begin
        if (!bus.hold) commit = 1'b1;
      end
      default: state_d = FILL;
    endcase
    // Stale shadow bytes above the frame length are replaced by PAD.
    if (commit) begin
      for (int i = 0; i < SORT_N; i++)
        frm_d[i] = (LEN_W'(i) < commit_len) ? shadow_d[i] : PAD;
      fcnt_d      = 3'd0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      state_d     = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fcnt_q      <= 3'd0;
      len_q       <= '0;
      frame_cnt_q <= 16'd0;
      up_q        <= 1'b0;
      for (int i = 0; i < SORT_N; i++) begin
        shadow_q[i] <= PAD;
        frm_q[i]    <= PAD;
      end
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      up_q        <= up_d;
      for (int i = 0; i < SORT_N; i++) begin
        shadow_q[i] <= shadow_d[i];
        frm_q[i]    <= frm_d[i];
      end
    end
  end

  sort_align_delay #(.DEPTH(SORT_LAT + 1), .LW(LEN_W)) u_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pulse  (commit),
    .in_len    (commit_len),
    .out_pulse (bus.sorted_valid),
    .out_len   (bus.sorted_len)
  );

  assign bus.in_ready  = in_ready;
  assign bus.frm1      = frm_q[0];
  assign bus.frm2      = frm_q[1];
  assign bus.frm3      = frm_q[2];
  assign bus.frm4      = frm_q[3];
  assign bus.frm5      = frm_q[4];
  assign bus.frm6      = frm_q[5];
  assign bus.frm7      = frm_q[6];
  assign bus.frm8      = frm_q[7];
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_sort_loader.sv
// Randomized and directed bench for sort_loader against a frame-level queue model.
module tb_sort_loader;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  sort_loader_if bus ();

  sort_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0]  cur[$];
  logic [7:0]  exp_frm [8];
  logic [15:0] exp_cnt;
  logic        pend_m;
  logic        up_m;
  int          edge_n;
  int          pulse_at [int];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [7:0] got [8];
    got = '{bus.frm1, bus.frm2, bus.frm3, bus.frm4, bus.frm5, bus.frm6, bus.frm7, bus.frm8};
    checkOutput("in_ready", 32'(bus.in_ready), 32'(up_m && !pend_m));
    for (int i = 0; i < 8; i++) checkOutput($sformatf("frm%0d", i + 1), 32'(got[i]), 32'(exp_frm[i]));
    checkOutput("sorted_valid", 32'(bus.sorted_valid), 32'(pulse_at.exists(edge_n)));
    if (pulse_at.exists(edge_n))
      checkOutput("sorted_len", 32'(bus.sorted_len), 32'(pulse_at[edge_n]));
    checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_frm1", 32'(bus.frm1), 32'd0);
    checkOutput("rst_frm8", 32'(bus.frm8), 32'd0);
    checkOutput("rst_valid", 32'(bus.sorted_valid), 32'd0);
    checkOutput("rst_len", 32'(bus.sorted_len), 32'd0);
    checkOutput("rst_cnt", 32'(bus.frame_cnt), 32'd0);
  endtask

  task automatic clearModel();
    cur.delete();
    pend_m  = 1'b0;
    up_m    = 1'b0;
    exp_cnt = 16'd0;
    for (int i = 0; i < 8; i++) exp_frm[i] = 8'h00;
    pulse_at.delete();
  endtask

  // Called just after a negedge: drive one cycle, predict the coming edge, then check.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic h);
    logic commit_m;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.hold     = h;
    commit_m = 1'b0;
    if (up_m && !pend_m) begin
      if (v) begin
        cur.push_back(d);
        if (cur.size() == 8 || l) begin
          if (h) pend_m = 1'b1;
          else   commit_m = 1'b1;
        end
      end
    end else if (up_m && pend_m && !h) begin
      commit_m = 1'b1;
    end
    if (commit_m) begin
      for (int i = 0; i < 8; i++) exp_frm[i] = (i < cur.size()) ? cur[i] : 8'h00;
      pulse_at[edge_n + 3] = cur.size();
      exp_cnt = exp_cnt + 16'd1;
      cur.delete();
      pend_m = 1'b0;
    end
    up_m = 1'b1;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.hold     = 1'b0;
    #1 checkResetValues();
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.hold     = 1'b0;
    edge_n = 0;
    clearModel();
    @(negedge clk);
    checkResetValues();
    #2 rst_n = 1'b1;
    idle(2);

    $display("[TB] full frame");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    checkOutput("full_frm1", 32'(bus.frm1), 32'h10);
    checkOutput("full_frm8", 32'(bus.frm8), 32'h17);
    checkOutput("full_cnt", 32'(bus.frame_cnt), 32'd1);
    idle(4);

    $display("[TB] short frame");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
    checkOutput("short_frm3", 32'(bus.frm3), 32'h80);
    checkOutput("short_frm4", 32'(bus.frm4), 32'h00);
    idle(4);

    $display("[TB] hold at completion");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h47, 1'b0, 1'b1);
    checkOutput("pend_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("pend_frm1", 32'(bus.frm1), 32'h05);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("pend_exit_frm8", 32'(bus.frm8), 32'h47);
    checkOutput("pend_exit_ready", 32'(bus.in_ready), 32'd1);
    idle(4);

    $display("[TB] back-to-back singles");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    idle(4);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h21 + i), (i == 3), 1'b0);
    doReset();
    idle(4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("post_rst_frm1", 32'(bus.frm1), 32'h30);
    checkOutput("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);
    idle(4);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0);
    idle(6);

    $display("[TB] counter wrap");
    doReset();
    idle(1);
    for (int n = 0; n < 65536; n++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
    checkOutput("wrap_zero", 32'(bus.frame_cnt), 32'h0000);
    applyStimulus(1'b1, 8'h7E, 1'b1, 1'b0);
    checkOutput("wrap_one", 32'(bus.frame_cnt), 32'h0001);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sort_loader.md
# sort_loader

Upstream feeder for the 8-entry descending sorter. It accepts a byte stream over a valid/ready handshake and packs it into 8-byte frames in a shadow buffer. Each complete or flushed frame is committed atomically onto the sorter's eight parallel inputs. A commit-aligned strobe and length are delayed to match the sorter's 2-cycle latency, so the consumer knows exactly when the sorter outputs hold a new frame and how many of the entries are real data.

## Interface
- `W`, 8, byte width; must equal the sorter data width.
- `PAD`, 8'h00, fill value for unused slots of a short frame; must be the minimum value so pads sort to the bottom.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in W: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept; a byte transfers when `in_valid && in_ready`.
- `in_last` in 1: qualifies the accepted byte as the final byte of a short frame.
- `hold` in 1: downstream stall; blocks a commit while high.
- `frm1`..`frm8` out W each: committed frame, wired to sorter `in1`..`in8`.
- `sorted_valid` out 1: one-cycle pulse while the sorter outputs hold the frame.
- `sorted_len` out 4: count of real bytes in that frame (1..8), valid with `sorted_valid`.
- `frame_cnt` out 16: number of commits since reset; wraps.

## Operation
- Shadow buffer: slots 1..8 plus a fill count `fcnt` (0..7). Accepted bytes are written to slot `fcnt+1` in arrival order.
- Frame completion occurs on an accepted byte that is either the 8th byte or carries `in_last=1`. `in_last` without `in_valid` is ignored; empty frames do not exist.
- Commit:
  - `frm1`..`frm8` are loaded with the shadow contents, including the completing byte.
  - Slots above the frame length are loaded with `PAD`.
  - `fcnt` returns to 0.
  - `frame_cnt` increments.
  - The frame length enters the alignment delay.
- FSM states:
  - FILL (`in_ready=1`):
    - Completion with `hold=0` commits on the same edge; the state stays FILL.
    - Completion with `hold=1` stores the byte, latches the length, and moves to PEND.
  - PEND (`in_ready=0`):
    - While `hold=1`, nothing changes.
    - On the first edge with `hold=0`, the loader commits and returns to FILL.
- `hold` has no effect in FILL until a completion occurs.
- `frm*` changes only on a commit.
- Alignment delay: a 3-stage register chain carrying {pulse, len[3:0]}. Stage 3 drives `sorted_valid` and `sorted_len`. The chain is fully pipelined, so back-to-back commits produce back-to-back pulses.
- `frame_cnt` rolls over from 16'hFFFF to 16'h0000.

## Timing
- Reset (async assert, sync release):
  - State = FILL.
  - `fcnt` = 0.
  - `in_ready` = 0 while `rst_n` is low and 1 from the first cycle after release.
  - `frm1`..`frm8` = `PAD`.
  - `sorted_valid` = 0 and `sorted_len` = 0.
  - `frame_cnt` = 0.
  - The delay chain and shadow buffer are cleared.
- Commit at edge E0:
  - `frm*` are new from E0.
  - The sorter latches them at E1 and registers the sorted result at E2.
  - `sorted_valid` is high for exactly the cycle E2..E3.
- Reset mid-fill or with pulses in flight: the partial frame and all pending pulses are discarded.
- Throughput: 1 byte per cycle sustained. Frames of 1..8 bytes commit with no bubble when `hold=0`.
- A PEND exit costs exactly 1 cycle with `in_ready=0` after `hold` falls: commit happens at that edge, and `in_ready=1` in the following cycle.

## Structure
- Shared package `sort_pkg`:
  - `SORT_N=8`
  - `SORT_W=8`
  - `LEN_W=4`
  - `SORT_LAT=2` (sorter latency; the delay depth is `SORT_LAT+1`)
  - state enum `{FILL, PEND}`
- Sub-module `sort_align_delay`: parameterised-depth shift chain for {pulse, len}; it is reused later by the unloader.

## Test plan
- Full frame:
  - Stimulus: bytes 0x10..0x17 back-to-back, `hold=0`.
  - Response: commit on the 8th edge with `frm1..8`=0x10..0x17. The sorter out = 0x17..0x10 with `sorted_valid` pulse 2 cycles after commit, `sorted_len`=8, and `frame_cnt`=1.
- Short frame:
  - Stimulus: bytes 0x05, 0xFF, 0x80 with `in_last` on 0x80.
  - Response: `frm`=05,FF,80,00,00,00,00,00 and `sorted_len`=3. The sorter out = FF,80,05,00×5.
- Hold at completion:
  - Stimulus: `hold=1` on the 8th byte.
  - Response: state PEND and `in_ready`=0; the next offered byte is not accepted and `frm*` are unchanged. After `hold` drops, commit at the next edge and `in_ready`=1 the cycle after.
- Back-to-back singles:
  - Stimulus: four beats each with `in_last=1`, values 0x01..0x04.
  - Response: four consecutive commits. `sorted_valid` is high for 4 consecutive cycles, each with `sorted_len`=1, and `frame_cnt`=4.
- Reset mid-operation:
  - Stimulus: `rst_n` low after 5 bytes, with one pulse in flight.
  - Response: all outputs are at reset values immediately and no `sorted_valid` pulse occurs. The next 8 bytes fill slot 1 first and commit normally.
- Counter wrap:
  - Stimulus: 65536 single-byte frames.
  - Response: `frame_cnt` returns to 0x0000 and the next frame gives 0x0001.
